nubus_master_ctrl: RTL and testbench

- Master-side sequencer for the NuBus interface.
- Accepts one local transaction request at a time and runs the bus tenure: arbitration, address (START*), data wait for ACK*, and for locked sequences the closing NULL-ATTENTION.
- Produces the per-cycle phase signals (arbcy, adrcy, dtacy, owner, locked, tm1n/tm0n) consumed by the NuBus driver, and returns status to the local requester.

---
 rtl/nubus_master_ctrl.sv | 126 ++++++++++++
 tb/tb_nubus_master_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/nubus_master_ctrl.sv
// nubus_master_ctrl: NuBus master tenure sequencer (arbitration, address, data, locked hold, attention).
// Define NUBUS_MASTER_TIMEOUT_EN to end an unacknowledged data phase after TIMEOUT_CYCLES clocks.
module nubus_master_ctrl #(
    parameter int ARB_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       nub_clk,
    input  logic       nub_reset,
    input  logic       cpu_valid,
    input  logic [1:0] cpu_tm,
    input  logic       cpu_lock,
    output logic       cpu_done,
    output logic [1:0] cpu_status,
    input  logic       nub_startn,
    input  logic       nub_ackn,
    input  logic [1:0] nub_tmn,
    input  logic       arb_won,
    output logic       mst_arbcy,
    output logic       mst_adrcy,
    output logic       mst_dtacy,
    output logic       mst_owner,
    output logic       mst_locked,
    output logic       mst_tm1n,
    output logic       mst_tm0n
);
    localparam logic [2:0] S_IDLE = 3'd0, S_ARB = 3'd1, S_ADDR = 3'd2,
                           S_DATA = 3'd3, S_HOLD = 3'd4, S_ATTN = 3'd5;
    localparam int AW = ARB_CYCLES > 1 ? $clog2(ARB_CYCLES) : 1;

    logic [2:0]    r_state, w_next;
    logic [AW-1:0] r_arb_cnt, w_arb_cnt;
    logic [1:0]    r_tm;
    logic          r_lock, r_busy;
    logic          w_latch, w_done, w_timeout, w_lock;
`ifdef NUBUS_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to_cnt;
`endif

    assign w_lock = w_latch ? cpu_lock : r_lock;

    // A request is never taken in the clock that reports the previous completion.
    always_comb begin
        w_next    = r_state;
        w_arb_cnt = r_arb_cnt;
        w_latch   = 1'b0;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: if (cpu_valid && !cpu_done) begin
                w_next    = S_ARB;
                w_arb_cnt = '0;
                w_latch   = 1'b1;
            end
            S_ARB: begin
                if (r_arb_cnt != AW'(ARB_CYCLES - 1)) w_arb_cnt = r_arb_cnt + 1'b1;
                else if (!arb_won) w_arb_cnt = '0;
                else if (!r_busy) w_next = S_ADDR;
            end
            S_ADDR: w_next = S_DATA;
            S_DATA: begin
                if (!nub_ackn) begin
                    w_done = 1'b1;
                    w_next = r_lock ? S_HOLD : S_IDLE;
                end
`ifdef NUBUS_MASTER_TIMEOUT_EN
                else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_done    = 1'b1;
                    w_timeout = 1'b1;
                    w_next    = r_lock ? S_ATTN : S_IDLE;
                end
`endif
            end
            S_HOLD: if (cpu_valid && !cpu_done) begin
                w_next  = cpu_lock ? S_ADDR : S_ATTN;
                w_latch = cpu_lock;
            end
            S_ATTN: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge nub_clk) begin
        if (nub_reset) begin
            r_state    <= S_IDLE;
            r_arb_cnt  <= '0;
            r_tm       <= 2'b11;
            r_lock     <= 1'b0;
            r_busy     <= 1'b0;
            cpu_done   <= 1'b0;
            cpu_status <= 2'b00;
            mst_arbcy  <= 1'b0;
            mst_adrcy  <= 1'b0;
            mst_dtacy  <= 1'b0;
            mst_owner  <= 1'b0;
            mst_locked <= 1'b0;
            mst_tm1n   <= 1'b1;
            mst_tm0n   <= 1'b1;
        end else begin
            r_state   <= w_next;
            r_arb_cnt <= w_arb_cnt;
            if (w_latch) begin
                r_tm   <= cpu_tm;
                r_lock <= cpu_lock;
            end
            // Attention cycles (START* and ACK* both low) leave the tracker alone.
            if (!nub_ackn && nub_startn) r_busy <= 1'b0;
            else if (!nub_startn && nub_ackn && !mst_owner) r_busy <= 1'b1;
            cpu_done <= w_done;
            if (w_done) cpu_status <= w_timeout ? 2'b00 : nub_tmn;
            mst_arbcy  <= w_next != S_IDLE;
            mst_adrcy  <= w_next == S_ADDR;
            mst_dtacy  <= w_next == S_DATA;
            mst_owner  <= w_next inside {S_ADDR, S_DATA, S_HOLD, S_ATTN};
            mst_locked <= (w_next inside {S_ADDR, S_DATA, S_HOLD}) && w_lock;
            {mst_tm1n, mst_tm0n} <= (w_next == S_ADDR) ? (w_latch ? cpu_tm : r_tm) : 2'b11;
        end
    end

`ifdef NUBUS_MASTER_TIMEOUT_EN
    always_ff @(posedge nub_clk) begin
        if (nub_reset) r_to_cnt <= '0;
        else r_to_cnt <= (r_state == S_DATA && w_next == S_DATA) ? r_to_cnt + 1'b1 : '0;
    end
`endif
endmodule

// File: tb/tb_nubus_master_ctrl.sv
// tb_nubus_master_ctrl: drives whole NuBus tenures and checks every clock against a
// timeline derived from the tenure rules (arbitration rounds, one address clock, ACK latency).
module tb_nubus_master_ctrl;
    localparam int ARB = 2;
    localparam int TO = 8;
    localparam logic [6:0] P_IDLE = 7'b0000011, P_ARB = 7'b1000011,
                           P_HOLD = 7'b1001111, P_ATTN = 7'b1001011;

    logic nub_clk = 1'b0, nub_reset, cpu_valid, cpu_lock, cpu_done;
    logic [1:0] cpu_tm, cpu_status, nub_tmn;
    logic nub_startn, nub_ackn, arb_won;
    logic mst_arbcy, mst_adrcy, mst_dtacy, mst_owner, mst_locked, mst_tm1n, mst_tm0n;
    logic [6:0] w_ph;
    int errors = 0, checks = 0;
    bit held, gap;

    assign w_ph = {mst_arbcy, mst_adrcy, mst_dtacy, mst_owner, mst_locked, mst_tm1n, mst_tm0n};

    always #5 nub_clk = ~nub_clk;

    nubus_master_ctrl #(.ARB_CYCLES(ARB), .TIMEOUT_CYCLES(TO)) dut (
        .nub_clk(nub_clk), .nub_reset(nub_reset), .cpu_valid(cpu_valid), .cpu_tm(cpu_tm),
        .cpu_lock(cpu_lock), .cpu_done(cpu_done), .cpu_status(cpu_status),
        .nub_startn(nub_startn), .nub_ackn(nub_ackn), .nub_tmn(nub_tmn), .arb_won(arb_won),
        .mst_arbcy(mst_arbcy), .mst_adrcy(mst_adrcy), .mst_dtacy(mst_dtacy),
        .mst_owner(mst_owner), .mst_locked(mst_locked), .mst_tm1n(mst_tm1n), .mst_tm0n(mst_tm0n)
    );

    function automatic logic [6:0] ph(input logic a, input logic ad, input logic d,
                                      input logic o, input logic l, input logic [1:0] tm);
        return {a, ad, d, o, l, tm};
    endfunction

    task automatic tick();
        @(posedge nub_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_ph(input string tag, input logic [6:0] e, input logic d);
        chk({tag, "_phase"}, {1'b0, w_ph}, {1'b0, e});
        chk({tag, "_done"}, {7'd0, cpu_done}, {7'd0, d});
    endtask

    task automatic idle(input int n);
        cpu_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            chk_ph("idle", held ? P_HOLD : P_IDLE, 1'b0);
        end
        gap = 1'b0;
    endtask

    // Request from IDLE goes through lost+1 arbitration rounds; from HOLD a locked one goes straight to ADDR.
    task automatic arb_addr(input int lost, input logic [1:0] tm, input logic lk);
        cpu_valid = 1'b1;
        cpu_tm = tm;
        cpu_lock = lk;
        arb_won = 1'($urandom);
        if (gap) begin
            tick();
            chk_ph("gap", held ? P_HOLD : P_IDLE, 1'b0);
        end
        gap = 1'b0;
        if (held && !lk) begin
            tick();
            chk_ph("attn", P_ATTN, 1'b0);
            tick();
            chk_ph("attn_idle", P_IDLE, 1'b0);
            held = 1'b0;
        end
        if (!held) for (int i = 0; i < ARB * (lost + 1); i++) begin
            tick();
            chk_ph("arb", P_ARB, 1'b0);
            arb_won = (i % ARB == ARB - 1) ? (i / ARB >= lost) : 1'($urandom);
            cpu_tm = 2'($urandom);
            cpu_lock = 1'($urandom);
        end
        tick();
        chk_ph("addr", ph(1, 1, 0, 1, lk, tm), 1'b0);
        held = 1'b0;
    endtask

    task automatic data_done(input int dly, input logic [1:0] st, input logic lk);
        for (int j = 0; j < dly; j++) begin
            tick();
            chk_ph("data", ph(1, 0, 1, 1, lk, 2'b11), 1'b0);
            nub_ackn = (j != dly - 1);
            nub_tmn = (j == dly - 1) ? st : 2'($urandom);
            cpu_tm = 2'($urandom);
            cpu_lock = 1'($urandom);
        end
        tick();
        nub_ackn = 1'b1;
        chk_ph("done", lk ? P_HOLD : P_IDLE, 1'b1);
        chk("status", {6'd0, cpu_status}, {6'd0, st});
        held = lk;
        gap = 1'b1;
    endtask

    initial begin
        nub_reset = 1'b1; cpu_valid = 1'b0; cpu_tm = 2'b11; cpu_lock = 1'b0;
        nub_startn = 1'b1; nub_ackn = 1'b1; nub_tmn = 2'b11; arb_won = 1'b0;
        held = 1'b0; gap = 1'b0;
        tick();
        tick();
        chk_ph("reset", P_IDLE, 1'b0);
        chk("reset_status", {6'd0, cpu_status}, 8'd0);
        nub_reset = 1'b0;
        // basic read, then lost arbitration, then locked pair closed by an unlocked request
        arb_addr(0, 2'b11, 1'b0); data_done(3, 2'b00, 1'b0);
        idle(2);
        arb_addr(2, 2'b10, 1'b0); data_done(1, 2'b01, 1'b0);
        arb_addr(0, 2'b01, 1'b1); data_done(2, 2'b10, 1'b1);
        arb_addr(0, 2'b00, 1'b1); data_done(1, 2'b11, 1'b1);
        arb_addr(1, 2'b11, 1'b0); data_done(2, 2'b01, 1'b0);
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            arb_addr($urandom_range(0, 2), 2'($urandom), $urandom_range(0, 2) == 0);
            data_done($urandom_range(1, 6), 2'($urandom), dut.r_lock);
        end
        if (held) begin
            arb_addr(0, 2'b11, 1'b0);
            data_done(1, 2'b00, 1'b0);
        end
        idle(1);
        // another master: START* in ARB clock 0, attention in clock 3, ACK* in clock 5 -> ADDR at clock 7
        cpu_valid = 1'b1; cpu_tm = 2'b10; cpu_lock = 1'b0; arb_won = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_ph("busy", i < 7 ? P_ARB : ph(1, 1, 0, 1, 0, 2'b10), 1'b0);
            nub_startn = !(i == 0 || i == 3);
            nub_ackn = !(i == 3 || i == 5);
        end
        nub_startn = 1'b1; nub_ackn = 1'b1;
        data_done(2, 2'b11, 1'b0);
        idle(1);
        arb_addr(0, 2'b01, 1'b0);
        nub_tmn = 2'b11;
`ifdef NUBUS_MASTER_TIMEOUT_EN
        for (int j = 0; j < TO; j++) begin
            tick();
            chk_ph("to_data", ph(1, 0, 1, 1, 0, 2'b11), 1'b0);
        end
        tick();
        chk_ph("timeout", P_IDLE, 1'b1);
        chk("timeout_status", {6'd0, cpu_status}, 8'd0);
        idle(1);
        arb_addr(0, 2'b01, 1'b0); data_done(1, 2'b10, 1'b0);
        idle(1);
        arb_addr(0, 2'b01, 1'b0);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk_ph("pre_reset", ph(1, 0, 1, 1, 0, 2'b11), 1'b0);
        end
`else
        for (int j = 0; j < 20; j++) begin
            tick();
            chk_ph("no_timeout", ph(1, 0, 1, 1, 0, 2'b11), 1'b0);
        end
`endif
        nub_reset = 1'b1;
        tick();
        chk_ph("reset_mid", P_IDLE, 1'b0);
        chk("reset_mid_status", {6'd0, cpu_status}, 8'd0);
        nub_reset = 1'b0; held = 1'b0; gap = 1'b0;
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
